// File: rtl/seq_multiword_adder.sv
// Sequential wide adder: one N-bit ripple slice reused WORDS times, LSB slice first.
// Optional macro SEQ_ADD_OVERFLOW_EN adds a registered signed-overflow output o_Overflow.

module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];
endmodule

// state | meaning
// IDLE  | ready for operands
// ADD   | one slice summed per clock, idx selects the slice
// DONE  | result held until the consumer takes it
module seq_multiword_adder #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [N*WORDS-1:0] i_A,
    input  logic [N*WORDS-1:0] i_B,
    input  logic             i_Cin,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [N*WORDS-1:0] o_Sum,
    output logic             o_Cout
`ifdef SEQ_ADD_OVERFLOW_EN
    ,
    output logic             o_Overflow
`endif
);
    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     sum_reg;
    logic             cout_reg;

    logic [N-1:0]     a_slice;
    logic [N-1:0]     b_slice;
    logic [N-1:0]     slice_sum;
    logic             slice_cout;
    logic             last_slice;

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                a_slice = op_a[w*N +: N];
                b_slice = op_b[w*N +: N];
            end
        end
    end

    assign last_slice = (idx == IDX_W'(WORDS - 1));

    ripple_carry_adder #(.N(N)) u_rca (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

`ifdef SEQ_ADD_OVERFLOW_EN
    logic ovf_reg;
    logic msb_cin;

    // The slice only exposes its final carry, so recover the carry into the MSB.
    assign msb_cin    = op_a[W-1] ^ op_b[W-1] ^ slice_sum[N-1];
    assign o_Overflow = ovf_reg;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= IDLE;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
`ifdef SEQ_ADD_OVERFLOW_EN
            ovf_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_Valid) begin
                        op_a  <= i_A;
                        op_b  <= i_B;
                        carry <= i_Cin;
                        idx   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx == IDX_W'(w)) sum_reg[w*N +: N] <= slice_sum;
                    end
                    carry <= slice_cout;
                    if (last_slice) begin
                        cout_reg <= slice_cout;
`ifdef SEQ_ADD_OVERFLOW_EN
                        ovf_reg  <= msb_cin ^ slice_cout;
`endif
                        state    <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (i_Ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_Ready = (state == IDLE);
    assign o_Valid = (state == DONE);
    assign o_Sum   = sum_reg;
    assign o_Cout  = cout_reg;
endmodule
